gol_step_sequencer: RTL and testbench



---
 rtl/gol_pkg.sv | 23 ++
 rtl/sum_8.sv | 21 ++
 rtl/gol_step_sequencer.sv | 155 +++++++++++++++
 tb/tb_gol_step_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game of Life step sequencer.
// Neighbour offsets are listed in the same order as the sum_8 input bits.
package gol_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EVAL   = 2'd1,
    S_COMMIT = 2'd2
  } gol_state_t;

  localparam int NBR_N = 8;
  localparam int NBR_DR [NBR_N] = '{-1, -1, -1,  0, 0,  1, 1, 1};
  localparam int NBR_DC [NBR_N] = '{-1,  0,  1, -1, 1, -1, 0, 1};

  localparam logic [3:0] BIRTH   = 4'd3;
  localparam logic [3:0] SURVIVE = 4'd2;

  // Keeps counter widths at least 1 bit for degenerate 1-row or 1-column boards.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sum_8.sv
// Combinational population count of eight neighbour bits.
// The count 0..8 is returned as carry o_c plus low bits o_out.
module sum_8 (
  input  logic [7:0] i_bits,
  output logic [2:0] o_out,
  output logic       o_c
);

  logic [3:0] w_sum;

  always_comb begin
    w_sum = 4'd0;
    for (int k = 0; k < 8; k++) begin
      w_sum = w_sum + {3'd0, i_bits[k]};
    end
  end

  assign o_out = w_sum[2:0];
  assign o_c   = w_sum[3];

endmodule

// File: rtl/gol_step_sequencer.sv
// Evaluates one Game of Life generation, one cell per clock, through a shared sum_8.
// Define GOL_WRAP_EN for a toroidal board; otherwise off-board neighbours read as dead.
//
// state    | meaning
// S_IDLE   | waiting; accepts load_en (priority) or start
// S_EVAL   | walking cells, writing next state into the shadow
// S_COMMIT | shadow copied to cells, gen_count advanced, done pulsed
module gol_step_sequencer
  import gol_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   load_en,
  input  logic [ROWS*COLS-1:0]   load_data,
  output logic [ROWS*COLS-1:0]   cells,
  output logic                   busy,
  output logic                   done,
  output logic [GEN_W-1:0]       gen_count
);

  localparam int NCELLS = ROWS * COLS;
  localparam int IDX_W  = clog2_min1(NCELLS);
  localparam int ROW_W  = clog2_min1(ROWS);
  localparam int COL_W  = clog2_min1(COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELLS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  gol_state_t        r_state;
  gol_state_t        w_next_state;
  logic [NCELLS-1:0] r_cells;
  logic [NCELLS-1:0] r_shadow;
  logic [IDX_W-1:0]  r_idx;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [GEN_W-1:0]  r_gen;

  logic [7:0]        w_nbrs;
  logic [2:0]        w_sum_out;
  logic              w_sum_c;
  logic [3:0]        w_count;
  logic              w_live;
  logic              w_last;

  // Neighbours always come from the committed board, never the shadow.
  always_comb begin
    int  nr;
    int  nc;
    int  nidx;
    logic ok;
    w_nbrs = '0;
    nr     = 0;
    nc     = 0;
    nidx   = 0;
    ok     = 1'b0;
    for (int k = 0; k < NBR_N; k++) begin
      nr = int'(r_row) + NBR_DR[k];
      nc = int'(r_col) + NBR_DC[k];
`ifdef GOL_WRAP_EN
      if (nr < 0) nr = ROWS - 1;
      else if (nr >= ROWS) nr = 0;
      if (nc < 0) nc = COLS - 1;
      else if (nc >= COLS) nc = 0;
      ok = 1'b1;
`else
      ok = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
`endif
      nidx      = ok ? (nr * COLS + nc) : 0;
      w_nbrs[k] = ok & r_cells[IDX_W'(nidx)];
    end
  end

  sum_8 u_sum_8 (
    .i_bits (w_nbrs),
    .o_out  (w_sum_out),
    .o_c    (w_sum_c)
  );

  assign w_count = {w_sum_c, w_sum_out};
  assign w_live  = (w_count == BIRTH) | (r_cells[r_idx] & (w_count == SURVIVE));
  assign w_last  = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (!load_en && start) w_next_state = S_EVAL;
      S_EVAL:   if (w_last) w_next_state = S_COMMIT;
      S_COMMIT: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_COMMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cells  <= '0;
      r_shadow <= '0;
      r_idx    <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_gen    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_en) begin
            r_cells <= load_data;
            r_gen   <= '0;
          end else if (start) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
          end
        end
        S_EVAL: begin
          r_shadow[r_idx] <= w_live;
          if (w_last) begin
            r_idx <= '0;
            r_row <= '0;
            r_col <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
            if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        S_COMMIT: begin
          r_cells <= r_shadow;
          r_gen   <= r_gen + GEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign cells     = r_cells;
  assign gen_count = r_gen;

endmodule

// File: tb/tb_gol_step_sequencer.sv
// Self-checking bench for gol_step_sequencer on the default 8x8 board.
// Honours GOL_WRAP_EN the same way as the design build.
module tb_gol_step_sequencer;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int GEN_W = 16;
  localparam int N     = ROWS * COLS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             load_en = 1'b0;
  logic [N-1:0]     load_data = '0;
  logic [N-1:0]     cells;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gen_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gol_step_sequencer #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load_en   (load_en),
    .load_data (load_data),
    .cells     (cells),
    .busy      (busy),
    .done      (done),
    .gen_count (gen_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic bit_at(input logic [N-1:0] b, input int idx);
    logic [N-1:0] t;
    t = b >> idx;
    return t[0];
  endfunction

  // Reference: the life rule applied to a whole board with plain arithmetic.
  function automatic logic [N-1:0] life(input logic [N-1:0] b);
    logic [N-1:0] nb;
    int cnt, rr, cc;
    logic alive, nxt;
    nb = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = r + dr;
              cc = c + dc;
`ifdef GOL_WRAP_EN
              rr = (rr + ROWS) % ROWS;
              cc = (cc + COLS) % COLS;
              cnt += int'(bit_at(b, rr * COLS + cc));
`else
              if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS)
                cnt += int'(bit_at(b, rr * COLS + cc));
`endif
            end
          end
        end
        alive = bit_at(b, r * COLS + c);
        nxt   = (cnt == 3) || (alive && cnt == 2);
        nb    = nb | (N'(nxt) << (r * COLS + c));
      end
    end
    return nb;
  endfunction

  task automatic load_board(input logic [N-1:0] b);
    @(negedge clk);
    load_en   = 1'b1;
    load_data = b;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Pulses start and follows the step to its done pulse; optional mid-step
  // load_en/start injection at EVAL cycle inj (0 disables).
  task automatic run_step(input int inj, output int lat, output int ndone);
    logic found;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    ndone = 0;
    found = 1'b0;
    while (!found && lat < 300) begin
      if (lat == inj) begin
        load_en   = 1'b1;
        load_data = '1;
        start     = 1'b1;
      end
      if (done) begin
        ndone++;
        found = 1'b1;
      end else begin
        @(negedge clk);
        load_en = 1'b0;
        start   = 1'b0;
        lat++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  initial begin
    logic [N-1:0] b, v, e, m;
    int lat, nd, steps, cyc;
    logic busy_seen;

    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] b, v, e, m;
    int lat, nd, steps, cyc;
    logic busy_seen, found;

    @(negedge clk);
    @(negedge clk);
    check("reset_cells", 64'(cells), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_gen", 64'(gen_count), 64'd0);
    rst_n = 1'b1;

    // Blinker: horizontal row 3 cols 2-4 becomes vertical col 3 rows 2-4.
    b = '0; b[26] = 1'b1; b[27] = 1'b1; b[28] = 1'b1;
    v = '0; v[19] = 1'b1; v[27] = 1'b1; v[35] = 1'b1;
    load_board(b);
    check("blinker_load", 64'(cells), 64'(b));
    run_step(0, lat, nd);
    check("blinker_latency", 64'(lat), 64'(N + 1));
    check("blinker_done_once", 64'(nd), 64'd1);
    check("blinker_vertical", 64'(cells), 64'(v));
    check("blinker_model", 64'(cells), 64'(life(b)));
    check("blinker_gen1", 64'(gen_count), 64'd1);
    check("blinker_idle_busy", 64'(busy), 64'd0);
    run_step(0, lat, nd);
    check("blinker_restore", 64'(cells), 64'(b));
    check("blinker_gen2", 64'(gen_count), 64'd2);

    // Still life block.
    b = '0; b[9] = 1'b1; b[10] = 1'b1; b[17] = 1'b1; b[18] = 1'b1;
    load_board(b);
    check("block_gen_cleared", 64'(gen_count), 64'd0);
    for (int s = 0; s < 3; s++) run_step(0, lat, nd);
    check("block_unchanged", 64'(cells), 64'(b));
    check("block_gen3", 64'(gen_count), 64'd3);

    // Edge behaviour: vertical line at col 0, rows 7,0,1.
    b = '0; b[0] = 1'b1; b[8] = 1'b1; b[56] = 1'b1;
    e = '0;
`ifdef GOL_WRAP_EN
    e[7] = 1'b1; e[0] = 1'b1; e[1] = 1'b1;
`endif
    load_board(b);
    run_step(0, lat, nd);
    check("edge_const", 64'(cells), 64'(e));
    check("edge_model", 64'(cells), 64'(life(b)));

    // Busy protection: load_en all-ones plus start at EVAL cycle 10.
    b = '0; b[26] = 1'b1; b[27] = 1'b1; b[28] = 1'b1; b[45] = 1'b1; b[46] = 1'b1; b[54] = 1'b1;
    load_board(b);
    run_step(10, lat, nd);
    check("busy_prot_cells", 64'(cells), 64'(life(b)));
    check("busy_prot_done_once", 64'(nd), 64'd1);
    check("busy_prot_gen", 64'(gen_count), 64'd1);
    check("busy_prot_latency", 64'(lat), 64'(N + 1));

    // Reset during EVAL cycle 30 of the second step.
    b = {$urandom, $urandom};
    load_board(b);
    run_step(0, lat, nd);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 30; k++) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset_cells", 64'(cells), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_gen", 64'(gen_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_step(0, lat, nd);
    check("post_reset_empty", 64'(cells), 64'd0);
    check("post_reset_gen", 64'(gen_count), 64'd1);

    // Simultaneous load_en and start in IDLE: load wins.
    b = {$urandom, $urandom};
    @(negedge clk);
    load_en   = 1'b1;
    start     = 1'b1;
    load_data = b;
    @(negedge clk);
    load_en   = 1'b0;
    start     = 1'b0;
    busy_seen = busy;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check("simul_cells", 64'(cells), 64'(b));
    check("simul_gen", 64'(gen_count), 64'd0);
    check("simul_no_busy", 64'(busy_seen), 64'd0);

    // Back-to-back: start held high, steps repeat every N+2 cycles.
    b = {$urandom, $urandom};
    load_board(b);
    @(negedge clk);
    start = 1'b1;
    cyc   = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_first_done", 64'(done), 64'd1);
    cyc = 0;
    @(negedge clk);
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("b2b_period", 64'(cyc), 64'(N + 2));
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("b2b_stopped", 64'(busy), 64'd0);
    check("b2b_cells", 64'(cells), 64'(life(life(b))));
    check("b2b_gen", 64'(gen_count), 64'd2);

    // Random boards over a few generations each.
    for (int t = 0; t < 8; t++) begin
      b = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) b = b & {$urandom, $urandom};
      load_board(b);
      m = b;
      steps = $urandom_range(3, 1);
      for (int s = 0; s < steps; s++) begin
        run_step(0, lat, nd);
        m = life(m);
        check($sformatf("rand%0d_step%0d", t, s), 64'(cells), 64'(m));
      end
      check($sformatf("rand%0d_gen", t), 64'(gen_count), 64'(steps));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
